// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for the AES inverse cipher: LOAD, NUM_ROUNDS-1 InvMixColumns rounds, FINAL, DONE.
// Optional macro AES_DEC_KEY_WAIT_EN stalls every step until key_valid is high.
module aes_dec_round_ctrl #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic       key_valid,
   input  logic       out_ack,
   output logic [4:0] round_idx,
   output logic       sel_load,
   output logic       sel_inv_mix,
   output logic       state_en,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_t;

   localparam logic [4:0] IDX_FIRST = 5'(NUM_ROUNDS);

   state_t     state_q, state_d;
   logic [4:0] round_idx_q, round_idx_d;
   logic       step;

`ifdef AES_DEC_KEY_WAIT_EN
   assign step = key_valid;
`else
   logic unused_key_valid;
   assign unused_key_valid = key_valid;
   assign step = 1'b1;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         round_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         round_idx_q <= round_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      round_idx_d = round_idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               round_idx_d = IDX_FIRST;
            end
         end
         S_LOAD: begin
            if (step) begin
               state_d     = S_ROUND;
               round_idx_d = IDX_FIRST - 5'd1;
            end
         end
         S_ROUND: begin
            // The <= 1 compare also keeps the index from ever wrapping below zero.
            if (step) begin
               if (round_idx_q <= 5'd1) begin
                  state_d     = S_FINAL;
                  round_idx_d = '0;
               end else begin
                  round_idx_d = round_idx_q - 5'd1;
               end
            end
         end
         S_FINAL: begin
            if (step) begin
               state_d     = S_DONE;
               round_idx_d = '0;
            end
         end
         S_DONE: begin
            if (out_ack) begin
               if (start) begin
                  state_d     = S_LOAD;
                  round_idx_d = IDX_FIRST;
               end else begin
                  state_d     = S_IDLE;
                  round_idx_d = '0;
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            round_idx_d = '0;
         end
      endcase
   end

   always_comb begin
      round_idx   = round_idx_q;
      sel_load    = 1'b0;
      sel_inv_mix = 1'b0;
      state_en    = 1'b0;
      busy        = (state_q != S_IDLE);
      done        = 1'b0;
      case (state_q)
         S_LOAD: begin
            sel_load = 1'b1;
            state_en = step;
         end
         S_ROUND: begin
            sel_inv_mix = 1'b1;
            state_en    = step;
         end
         S_FINAL: begin
            state_en = step;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            round_idx = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: directed latency/handshake/reset cases plus random stimulus,
// checked against a block-position model for NUM_ROUNDS=10 and NUM_ROUNDS=14 instances.
module tb_aes_dec_round_ctrl;

   localparam int unsigned NR_A = 10;
   localparam int unsigned NR_B = 14;

   logic clk = 1'b0;
   logic n_rst, start, key_valid, out_ack;

   logic [4:0] idx_a, idx_b;
   logic       ld_a, mx_a, en_a, bz_a, dn_a;
   logic       ld_b, mx_b, en_b, bz_b, dn_b;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   // Model: position inside a block. 0 = idle, 1..nr+1 = load/round/final steps, nr+2 = done.
   int unsigned pos_a = 0, pos_b = 0, prev_a = 0, prev_b = 0;
   int unsigned encnt_a = 0, encnt_b = 0;

   always #5 clk = ~clk;

   aes_dec_round_ctrl #(.NUM_ROUNDS(NR_A)) u_dut_a (
      .clk(clk), .n_rst(n_rst), .start(start), .key_valid(key_valid), .out_ack(out_ack),
      .round_idx(idx_a), .sel_load(ld_a), .sel_inv_mix(mx_a), .state_en(en_a),
      .busy(bz_a), .done(dn_a)
   );

   aes_dec_round_ctrl #(.NUM_ROUNDS(NR_B)) u_dut_b (
      .clk(clk), .n_rst(n_rst), .start(start), .key_valid(key_valid), .out_ack(out_ack),
      .round_idx(idx_b), .sel_load(ld_b), .sel_inv_mix(mx_b), .state_en(en_b),
      .busy(bz_b), .done(dn_b)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   function automatic logic step_ok();
`ifdef AES_DEC_KEY_WAIT_EN
      return key_valid;
`else
      return 1'b1;
`endif
   endfunction

   function automatic int unsigned next_pos(input int unsigned pos, input int unsigned nr);
      if (!n_rst) return 0;
      if (pos == 0) return start ? 1 : 0;
      if (pos <= nr + 1) return step_ok() ? pos + 1 : pos;
      if (out_ack) return start ? 1 : 0;
      return pos;
   endfunction

   task automatic check_dut(input string nm, input int unsigned nr, input int unsigned pos,
                            input int unsigned prev, inout int unsigned encnt,
                            input logic [4:0] idx, input logic ld, input logic mx,
                            input logic en, input logic bz, input logic dn);
      logic        active;
      int unsigned e_idx;
      logic [4:0]  e_flags;
      active  = (pos >= 1) && (pos <= nr + 1);
      e_idx   = active ? (nr + 1 - pos) : 0;
      e_flags = {pos == 1, (pos >= 2) && (pos <= nr), active && step_ok(), pos != 0, pos == nr + 2};
      check({nm, "_round_idx"}, idx, e_idx);
      check({nm, "_ld_mx_en_busy_done"}, {ld, mx, en, bz, dn}, e_flags);
      check({nm, "_idx_no_underflow"}, (idx <= 5'(nr)) ? 1 : 0, 1);
      if (pos == nr + 2 && prev == nr + 1) check({nm, "_state_en_pulses"}, encnt, nr + 1);
      if (active) encnt += en;
      else encnt = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      prev_a = pos_a;
      prev_b = pos_b;
      pos_a  = next_pos(pos_a, NR_A);
      pos_b  = next_pos(pos_b, NR_B);
      @(negedge clk);
      check_dut("a", NR_A, pos_a, prev_a, encnt_a, idx_a, ld_a, mx_a, en_a, bz_a, dn_a);
      check_dut("b", NR_B, pos_b, prev_b, encnt_b, idx_b, ld_b, mx_b, en_b, bz_b, dn_b);
   endtask

   task automatic model_reset();
      pos_a = 0; pos_b = 0; prev_a = 0; prev_b = 0; encnt_a = 0; encnt_b = 0;
   endtask

   initial begin
      int unsigned lat_a, lat_b, done_cnt_a, stall_left, exp_lat_a, exp_lat_b;
      bit found;

      n_rst = 1'b0; start = 1'b0; key_valid = 1'b1; out_ack = 1'b0;
      #1;
      check("reset_a_outputs", {idx_a, ld_a, mx_a, en_a, bz_a, dn_a}, 0);
      check("reset_b_outputs", {idx_b, ld_b, mx_b, en_b, bz_b, dn_b}, 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      tick();

      // Single block: start pulse, hold done without ack, then ack.
      start = 1'b1;
      tick();
      start = 1'b0;
      lat_a = 0; lat_b = 0; done_cnt_a = 0; stall_left = 0;
`ifdef AES_DEC_KEY_WAIT_EN
      exp_lat_a = NR_A + 5; exp_lat_b = NR_B + 5;
`else
      exp_lat_a = NR_A + 2; exp_lat_b = NR_B + 2;
`endif
      if (dn_a) lat_a = 1;
      for (int unsigned c = 2; c <= 20; c++) begin
`ifdef AES_DEC_KEY_WAIT_EN
         if (stall_left == 0 && idx_a == 5'd7 && ld_a == 1'b0 && mx_a == 1'b1) stall_left = 3;
         key_valid = (stall_left == 0);
         if (stall_left != 0) stall_left--;
`endif
         tick();
         if (dn_a) done_cnt_a++;
         if (dn_a && lat_a == 0) lat_a = c;
         if (dn_b && lat_b == 0) lat_b = c;
      end
      key_valid = 1'b1;
      check("latency_done_a", lat_a, exp_lat_a);
      check("latency_done_b", lat_b, exp_lat_b);
      check("done_hold_no_ack_a", done_cnt_a, 20 - exp_lat_a + 1);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check("ack_to_idle_a_busy", bz_a, 0);
      check("ack_to_idle_b_busy", bz_b, 0);
      tick();

      // Back-to-back stream: start and out_ack held high.
      start = 1'b1; out_ack = 1'b1;
      repeat (45) tick();
      start = 1'b0; out_ack = 1'b0;
      repeat (20) tick();
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;

      // Asynchronous reset in the middle of a block.
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int unsigned c = 0; c < 40 && !found; c++) begin
         if (idx_a == 5'd5) found = 1'b1;
         else tick();
      end
      check("reach_idx5_before_reset", found, 1);
      #2 n_rst = 1'b0;
      #1;
      check("async_reset_a_outputs", {idx_a, ld_a, mx_a, en_a, bz_a, dn_a}, 0);
      check("async_reset_b_outputs", {idx_b, ld_b, mx_b, en_b, bz_b, dn_b}, 0);
      model_reset();
      @(negedge clk);
      n_rst = 1'b1;
      out_ack = 1'b1;
      repeat (20) tick();
      out_ack = 1'b0;

      // Random traffic.
      for (int unsigned c = 0; c < 3000; c++) begin
         start     = ($urandom_range(0, 3) == 0);
         out_ack   = ($urandom_range(0, 2) == 0);
         key_valid = ($urandom_range(0, 4) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
